// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S master transmitter for 24-bit signed audio samples.
// Generates BCLK/DACLRCK from clk, buffers samples in a small FIFO and
// sends each popped sample MSB-first on both the left and right slots.
// The advance pulse marks every frame start and doubles as the synth's
// sample clock.
//
// Handshake: a sample is pushed on any rising clk edge where both
// sample_valid_i and sample_ready_o are high. sample_ready_o depends only
// on the registered FIFO level, so it never depends on sample_valid_i.
module audio_i2s_tx #(
    parameter int DATA_W     = 24,
    parameter int BCLK_HALF  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [DATA_W-1:0]               sample_in_i,
    input  logic                            sample_valid_i,
    output logic                            sample_ready_o,
    input  logic                            mute_i,
    input  logic                            clear_underrun_i,
    output logic                            advance_o,
    output logic                            underrun_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
    output logic                            aud_bclk_o,
    output logic                            aud_daclrck_o,
    output logic                            aud_dacdat_o
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int DIVW = $clog2(BCLK_HALF);

    // Bit clock generation state
    logic [DIVW-1:0]   div_q;
    logic              bclk_q;

    // Frame position: number of the current BCLK period within the frame
    logic [5:0]        bit_q;
    logic [5:0]        bit_d;

    // Sample being serialized in the current frame
    logic [DATA_W-1:0] shadow_q;
    logic [DATA_W-1:0] shadow_d;

    // Registered serial outputs and status
    logic              lrck_q;
    logic              lrck_d;
    logic              dat_q;
    logic              dat_d;
    logic              advance_q;
    logic              underrun_q;

    // Sample FIFO
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic [LW-1:0]     level_d;

    logic              div_tc;
    logic              fall;
    logic              frame_start;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign div_tc      = (div_q == DIVW'(BCLK_HALF - 1));
    // A fall event is the divider wrap that takes BCLK from 1 to 0.
    assign fall        = div_tc && bclk_q;
    assign frame_start = fall && (bit_q == 6'd63);
    assign fifo_empty  = (level_q == '0);
    assign sample_ready_o = (level_q != LW'(FIFO_DEPTH));
    assign push        = sample_valid_i && sample_ready_o;
    // A push in the same cycle as a frame start on an empty FIFO is not
    // visible to the pop; that frame underruns and the sample stays queued.
    assign pop         = frame_start && !fifo_empty;
    assign level_d     = level_q + LW'(push) - LW'(pop);

    // Next serial state, evaluated from the bit position after the fall event
    always_comb begin
        bit_d    = bit_q + 6'd1;
        lrck_d   = bit_d[5];
        dat_d    = 1'b0;
        shadow_d = shadow_q;
        if (frame_start) begin
            shadow_d = (pop && !mute_i) ? mem_q[rd_ptr_q] : '0;
        end
        // Left slot carries bits at b=1..DATA_W, right slot at b=33..32+DATA_W.
        for (int i = 0; i < DATA_W; i++) begin
            if (bit_d == 6'(DATA_W - i)) begin
                dat_d = shadow_q[i];
            end
            if (bit_d == 6'(DATA_W + 32 - i)) begin
                dat_d = shadow_q[i];
            end
        end
    end

    // BCLK divider: toggle BCLK every BCLK_HALF clk cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (div_tc) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
        end else begin
            div_q  <= div_q + DIVW'(1);
        end
    end

    // Serial state advances only on fall events; advance pulses at frame start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_q     <= 6'd63;
            shadow_q  <= '0;
            lrck_q    <= 1'b1;
            dat_q     <= 1'b0;
            advance_q <= 1'b0;
        end else begin
            advance_q <= frame_start;
            if (fall) begin
                bit_q    <= bit_d;
                shadow_q <= shadow_d;
                lrck_q   <= lrck_d;
                dat_q    <= dat_d;
            end
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= sample_in_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    // Sticky underrun flag; a new underrun wins over a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underrun_q <= 1'b0;
        end else if (frame_start && fifo_empty) begin
            underrun_q <= 1'b1;
        end else if (clear_underrun_i) begin
            underrun_q <= 1'b0;
        end
    end

    assign advance_o     = advance_q;
    assign underrun_o    = underrun_q;
    assign fifo_level_o  = level_q;
    assign aud_bclk_o    = bclk_q;
    assign aud_daclrck_o = lrck_q;
    assign aud_dacdat_o  = dat_q;

endmodule
